down_count_timer: RTL and testbench

Loadable, programmable down-counting timer that complements the four-bit up counter. Software or a controller loads a period, starts the block, and receives a one-cycle terminal-count pulse when the period expires. Counting advances only on cycles where `en` is high, so a prescaler or tick source can pace the timer. It sits beside the up counter in the timing/counting layer and provides interval and timeout generation.

---
 rtl/down_count_timer_pkg.sv | 13 +
 rtl/down_count_timer_ctrl.sv | 98 +++++++++
 rtl/down_count_timer.sv | 92 +++++++++
 tb/tb_down_count_timer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/down_count_timer_pkg.sv
// Shared types and defaults for the down-counting interval/timeout timer.
package down_count_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/down_count_timer_ctrl.sv
// Timer control FSM: sequences IDLE/LOADED/RUN/DONE and issues count-register controls.
// Define DOWN_COUNT_TIMER_AUTORELOAD_EN to reload at terminal count instead of entering DONE.
module down_count_timer_ctrl
  import down_count_timer_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic start,
  input  logic stop,
  input  logic en,
  input  logic count_is_one,
  output logic busy,
  output logic done,
  output logic load_cnt,
  output logic dec_cnt,
  output logic reload_cnt,
  output logic clear_cnt,
  output logic tc
);

  state_t r_state;
  state_t w_state_nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; load beats start, stop beats start
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (load) begin
          w_state_nxt = ST_LOADED;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_LOADED: begin
        if (!load && start && !stop) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_LOADED;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_LOADED;
        end else if (en && count_is_one) begin
`ifdef DOWN_COUNT_TIMER_AUTORELOAD_EN
          w_state_nxt = ST_RUN;
`else
          w_state_nxt = ST_DONE;
`endif
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: status from registered state, count controls per cycle
  always_comb begin
    busy       = (r_state == ST_RUN);
    done       = (r_state == ST_DONE);
    load_cnt   = 1'b0;
    dec_cnt    = 1'b0;
    reload_cnt = 1'b0;
    clear_cnt  = 1'b0;
    tc         = 1'b0;
    if (r_state == ST_RUN) begin
      if (!stop && en) begin
        if (count_is_one) begin
          tc = 1'b1;
`ifdef DOWN_COUNT_TIMER_AUTORELOAD_EN
          reload_cnt = 1'b1;
`else
          clear_cnt = 1'b1;
`endif
        end else begin
          dec_cnt = 1'b1;
        end
      end else begin
        dec_cnt = 1'b0;
      end
    end else begin
      load_cnt = load;
    end
  end

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counting timer with one-cycle registered terminal-count strobe.
// Optional auto-reload behaviour selected by DOWN_COUNT_TIMER_AUTORELOAD_EN.
module down_count_timer
  import down_count_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;
  logic             w_load_cnt;
  logic             w_dec_cnt;
  logic             w_reload_cnt;
  logic             w_clear_cnt;
  logic             w_tc;
  logic             w_count_is_one;

  assign w_count_is_one = (r_count == ONE);

  down_count_timer_ctrl u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .start        (start),
    .stop         (stop),
    .en           (en),
    .count_is_one (w_count_is_one),
    .busy         (busy),
    .done         (done),
    .load_cnt     (w_load_cnt),
    .dec_cnt      (w_dec_cnt),
    .reload_cnt   (w_reload_cnt),
    .clear_cnt    (w_clear_cnt),
    .tc           (w_tc)
  );

  // Reload register is writable in every state, including RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reload <= {WIDTH{1'b0}};
    end else if (load) begin
      r_reload <= load_val;
    end else begin
      r_reload <= r_reload;
    end
  end

  // Count register; a zero period wraps through 2^WIDTH-1 naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {WIDTH{1'b0}};
    end else if (w_load_cnt) begin
      r_count <= load_val;
    end else if (w_clear_cnt) begin
      r_count <= {WIDTH{1'b0}};
    end else if (w_reload_cnt) begin
      r_count <= r_reload;
    end else if (w_dec_cnt) begin
      r_count <= r_count - ONE;
    end else begin
      r_count <= r_count;
    end
  end

  // Terminal-count strobe lands together with the terminal count value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tc <= 1'b0;
    end else begin
      r_tc <= w_tc;
    end
  end

  assign count_out = r_count;
  assign tc_pulse  = r_tc;

endmodule

// File: tb/tb_down_count_timer.sv
// Directed self-checking bench for down_count_timer (one-shot and, when built
// with DOWN_COUNT_TIMER_AUTORELOAD_EN, auto-reload behaviour).
module tb_down_count_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       en = 1'b0;
  logic [3:0] count_out;
  logic       busy;
  logic       done;
  logic       tc_pulse;

  int n_checks = 0;
  int n_errors = 0;

  down_count_timer #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_val  (load_val),
    .start     (start),
    .stop      (stop),
    .en        (en),
    .count_out (count_out),
    .busy      (busy),
    .done      (done),
    .tc_pulse  (tc_pulse)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input int cnt, input int b, input int d, input int t);
    check_val({tag, ".count"}, int'(count_out), cnt);
    check_val({tag, ".busy"}, int'(busy), b);
    check_val({tag, ".done"}, int'(done), d);
    check_val({tag, ".tc"}, int'(tc_pulse), t);
  endtask

  initial begin
    #1;
    expect_state("por", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    expect_state("idle", 0, 0, 0, 0);

`ifndef DOWN_COUNT_TIMER_AUTORELOAD_EN
    // One-shot period 3
    load_val = 4'd3; load = 1'b1;
    tick(); load = 1'b0;
    expect_state("p3.load", 3, 0, 0, 0);
    start = 1'b1; en = 1'b1;
    tick(); start = 1'b0;
    expect_state("p3.start", 3, 1, 0, 0);
    tick(); expect_state("p3.c2", 2, 1, 0, 0);
    tick(); expect_state("p3.c1", 1, 1, 0, 0);
    tick(); expect_state("p3.tc", 0, 0, 1, 1);
    tick(); expect_state("p3.done", 0, 0, 1, 0);
    start = 1'b1;
    tick(); start = 1'b0;
    expect_state("done.start_ign", 0, 0, 1, 0);

    // Reset mid-RUN at count 5 takes effect without a clock edge
    load_val = 4'd7; load = 1'b1;
    tick(); load = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    expect_state("r.c5", 5, 1, 0, 0);
    rst = 1'b1;
    #1;
    expect_state("r.async", 0, 0, 0, 0);
    tick(); rst = 1'b0;
    tick();
    expect_state("r.idle", 0, 0, 0, 0);

    // Period 4, gated enable, stop/resume
    load_val = 4'd4; load = 1'b1; en = 1'b0;
    tick(); load = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    expect_state("g.run", 4, 1, 0, 0);
    en = 1'b1; tick(); expect_state("g.e1", 3, 1, 0, 0);
    en = 1'b0; tick(); expect_state("g.e0", 3, 1, 0, 0);
    en = 1'b1; tick(); expect_state("g.e2", 2, 1, 0, 0);
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_state("g.stop", 2, 0, 0, 0);
    end
    stop = 1'b0; start = 1'b1; en = 1'b0;
    tick(); start = 1'b0;
    expect_state("g.resume", 2, 1, 0, 0);
    en = 1'b1; tick(); expect_state("g.e3", 1, 1, 0, 0);
    en = 1'b0; tick(); expect_state("g.hold1", 1, 1, 0, 0);
    en = 1'b1; tick(); expect_state("g.tc", 0, 0, 1, 1);

    // Zero period gives 2^WIDTH enabled edges
    load_val = 4'd0; load = 1'b1;
    tick(); load = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    expect_state("z.run", 0, 1, 0, 0);
    for (int i = 0; i < 15; i++) begin
      tick(); expect_state("z.cnt", 15 - i, 1, 0, 0);
    end
    tick(); expect_state("z.tc", 0, 0, 1, 1);

    // start+stop together in LOADED; load during RUN leaves count alone
    load_val = 4'd5; load = 1'b1;
    tick(); load = 1'b0; start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    expect_state("ss.loaded", 5, 0, 0, 0);
    start = 1'b1;
    tick(); start = 1'b0;
    expect_state("ss.run", 5, 1, 0, 0);
    load_val = 4'd9; load = 1'b1;
    tick(); load = 1'b0;
    expect_state("lr.run", 4, 1, 0, 0);

    // load+start together in IDLE
    rst = 1'b1; tick(); rst = 1'b0; tick();
    load_val = 4'd6; load = 1'b1; start = 1'b1; en = 1'b1;
    tick(); load = 1'b0; start = 1'b0;
    expect_state("ls.loaded", 6, 0, 0, 0);
    tick(); expect_state("ls.hold", 6, 0, 0, 0);
`else
    // Auto-reload period 2, then reload value changed mid-period
    load_val = 4'd2; load = 1'b1;
    tick(); load = 1'b0; start = 1'b1; en = 1'b1;
    tick(); start = 1'b0;
    expect_state("ar.run", 2, 1, 0, 0);
    tick(); expect_state("ar.c1", 1, 1, 0, 0);
    tick(); expect_state("ar.tc1", 2, 1, 0, 1);
    load_val = 4'd5; load = 1'b1;
    tick(); load = 1'b0;
    expect_state("ar.c1b", 1, 1, 0, 0);
    tick(); expect_state("ar.tc2", 5, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(); expect_state("ar.cnt", 4 - i, 1, 0, 0);
    end
    tick(); expect_state("ar.tc3", 5, 1, 0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
